path_waypoint_streamer: RTL

// - Reader side of the pathfinder's explored-node table. The search engine writes this table; each entry links to its parent.
// - On start, walks the parent chain from goal_idx back to the root (start) entry and buffers the entries in a LIFO.
// - Then streams the waypoints in forward order (start -> goal) over a valid/ready interface to the cart-navigation logic.

---
 rtl/path_waypoint_streamer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/path_waypoint_streamer.sv
// Walks the explored-node parent chain from a goal entry back to the root,
// buffers it in a LIFO, then streams the waypoints start->goal over valid/ready.
module path_waypoint_streamer #(
    parameter int COORD_W  = 10,
    parameter int IDX_W    = 7,
    parameter int COST_W   = 16,
    parameter int MAX_PATH = 128
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic [IDX_W-1:0]                     goal_idx,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 error,
    output logic [$clog2(MAX_PATH+1)-1:0]        path_len,
    output logic                                 mem_rd_en,
    output logic [IDX_W-1:0]                     mem_rd_addr,
    input  logic [2*COORD_W+IDX_W+1+COST_W-1:0]  mem_rd_data,
    output logic                                 wp_valid,
    input  logic                                 wp_ready,
    output logic [COORD_W-1:0]                   wp_x,
    output logic [COORD_W-1:0]                   wp_y,
    output logic [COST_W-1:0]                    wp_cost,
    output logic                                 wp_last
);

    localparam int SP_W  = $clog2(MAX_PATH + 1);
    localparam int PTR_W = (MAX_PATH > 1) ? $clog2(MAX_PATH) : 1;
    localparam int WP_W  = 2 * COORD_W + COST_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAPTURE,
        S_EMIT,
        S_DONE,
        S_ERROR
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cur_idx_q, cur_idx_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [SP_W-1:0]    path_len_q, path_len_d;
    logic               push_en;
    logic [WP_W-1:0]    stack_q [MAX_PATH];

    // Table entry layout: {x, y, parent, is_root, cost}.
    logic [COST_W-1:0]  rd_cost;
    logic               rd_is_root;
    logic [IDX_W-1:0]   rd_parent;
    logic [COORD_W-1:0] rd_y;
    logic [COORD_W-1:0] rd_x;

    assign rd_cost    = mem_rd_data[COST_W-1:0];
    assign rd_is_root = mem_rd_data[COST_W];
    assign rd_parent  = mem_rd_data[COST_W+1 +: IDX_W];
    assign rd_y       = mem_rd_data[COST_W+1+IDX_W +: COORD_W];
    assign rd_x       = mem_rd_data[COST_W+1+IDX_W+COORD_W +: COORD_W];

    logic [SP_W-1:0] sp_top;
    logic [WP_W-1:0] top_entry;

    assign sp_top    = sp_q - SP_W'(1);
    assign top_entry = stack_q[sp_top[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_idx_q  <= '0;
            sp_q       <= '0;
            path_len_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            sp_q       <= sp_d;
            path_len_q <= path_len_d;
        end
    end

    // NOTE: the LIFO storage has no reset; sp_q alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_q[sp_q[PTR_W-1:0]] <= {rd_x, rd_y, rd_cost};
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_idx_d   = cur_idx_q;
        sp_d        = sp_q;
        path_len_d  = path_len_q;
        push_en     = 1'b0;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        wp_valid    = 1'b0;
        wp_x        = '0;
        wp_y        = '0;
        wp_cost     = '0;
        wp_last     = 1'b0;
        done        = 1'b0;
        error       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_idx_d  = goal_idx;
                    sp_d       = '0;
                    path_len_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = cur_idx_q;
                state_d     = S_CAPTURE;
            end
            S_CAPTURE: begin
                // A full LIFO with no root yet means an over-long chain or a parent loop.
                if (sp_q == SP_W'(MAX_PATH)) begin
                    state_d = S_ERROR;
                end else begin
                    push_en    = 1'b1;
                    sp_d       = sp_q + SP_W'(1);
                    path_len_d = sp_q + SP_W'(1);
                    if (rd_is_root) begin
                        state_d = S_EMIT;
                    end else begin
                        cur_idx_d = rd_parent;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_EMIT: begin
                wp_valid               = 1'b1;
                {wp_x, wp_y, wp_cost}  = top_entry;
                wp_last                = (sp_q == SP_W'(1));
                if (wp_ready) begin
                    sp_d = sp_top;
                    if (sp_q == SP_W'(1)) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            S_ERROR: begin
                error   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy     = (state_q != S_IDLE);
    assign path_len = path_len_q;

endmodule
